// File: rtl/mem_rsp_downsizer_if.sv
// Memory response bus bundle for mem_rsp_downsizer.
// Wide side: mem_rsp_valid/data/tag in, mem_rsp_ready out.
// Narrow side: rsp_valid/data/tag/beat/last out, rsp_ready in.
// slave  : view used by the downsizer itself.
// master : view used by whatever drives the wide side and sinks the beats.
interface mem_rsp_downsizer_if #(
    parameter int unsigned SRC_DATA_WIDTH = 512,
    parameter int unsigned DST_DATA_WIDTH = 128,
    parameter int unsigned TAG_WIDTH      = 8
);
    localparam int unsigned RATIO      = SRC_DATA_WIDTH / DST_DATA_WIDTH;
    localparam int unsigned BEAT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;

    logic                      mem_rsp_valid;
    logic [SRC_DATA_WIDTH-1:0] mem_rsp_data;
    logic [TAG_WIDTH-1:0]      mem_rsp_tag;
    logic                      mem_rsp_ready;

    logic                      rsp_valid;
    logic [DST_DATA_WIDTH-1:0] rsp_data;
    logic [TAG_WIDTH-1:0]      rsp_tag;
    logic [BEAT_WIDTH-1:0]     rsp_beat;
    logic                      rsp_last;
    logic                      rsp_ready;

    modport slave (
        input  mem_rsp_valid, mem_rsp_data, mem_rsp_tag, rsp_ready,
        output mem_rsp_ready, rsp_valid, rsp_data, rsp_tag, rsp_beat, rsp_last
    );

    modport master (
        output mem_rsp_valid, mem_rsp_data, mem_rsp_tag, rsp_ready,
        input  mem_rsp_ready, rsp_valid, rsp_data, rsp_tag, rsp_beat, rsp_last
    );
endinterface

// File: rtl/mem_rsp_downsizer.sv
// Serializes one wide memory response line into RATIO narrow beats.
// Ports: clk, reset_n (async active-low), bus (mem_rsp_downsizer_if.slave):
//   wide input  mem_rsp_valid/data/tag -> mem_rsp_ready
//   beat output rsp_valid/data/tag/beat/last <- rsp_ready
// Beat 0 carries the line LSBs. All beat outputs come straight from flops;
// mem_rsp_ready is combinational from rsp_ready so a new line can be taken
// on the same cycle the last beat leaves, giving zero-bubble streaming.
module mem_rsp_downsizer #(
    parameter int unsigned SRC_DATA_WIDTH = 512,
    parameter int unsigned DST_DATA_WIDTH = 128,
    parameter int unsigned TAG_WIDTH      = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mem_rsp_downsizer_if.slave   bus
);
    localparam int unsigned RATIO      = SRC_DATA_WIDTH / DST_DATA_WIDTH;
    localparam int unsigned BEAT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;

    typedef enum logic {IDLE, SEND} state_e;

    state_e                    state_q, state_d;
    logic [SRC_DATA_WIDTH-1:0] line_q, line_d;
    logic [TAG_WIDTH-1:0]      tag_q, tag_d;
    logic [BEAT_WIDTH-1:0]     beat_q, beat_d;
    logic                      valid_q, valid_d;
    logic                      last_q, last_d;

    logic                      in_hs;
    logic                      out_hs;
    logic [BEAT_WIDTH-1:0]     beat_inc;

    // Ready when idle, or when the final beat of the current line leaves now.
    assign bus.mem_rsp_ready = reset_n & ((state_q == IDLE) | (valid_q & bus.rsp_ready & last_q));

    assign in_hs  = bus.mem_rsp_valid & bus.mem_rsp_ready;
    assign out_hs = valid_q & bus.rsp_ready;

    // Next-state: advance on beat handshake, reload on line handshake.
    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        tag_d    = tag_q;
        beat_d   = beat_q;
        valid_d  = valid_q;
        last_d   = last_q;
        beat_inc = beat_q + BEAT_WIDTH'(1);

        if (out_hs) begin
            // Line buffer shifts down so the current beat is always the LSBs.
            line_d = line_q >> DST_DATA_WIDTH;
            if (last_q) begin
                state_d = IDLE;
                valid_d = 1'b0;
                beat_d  = '0;
                last_d  = 1'b0;
            end else begin
                beat_d = beat_inc;
                last_d = (beat_inc == BEAT_WIDTH'(RATIO - 1));
            end
        end

        // A new line overrides the wrap above when both happen together.
        if (in_hs) begin
            state_d = SEND;
            line_d  = bus.mem_rsp_data;
            tag_d   = bus.mem_rsp_tag;
            beat_d  = '0;
            valid_d = 1'b1;
            last_d  = (RATIO == 1);
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            line_q  <= '0;
            tag_q   <= '0;
            beat_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            tag_q   <= tag_d;
            beat_q  <= beat_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    assign bus.rsp_valid = valid_q;
    assign bus.rsp_data  = line_q[DST_DATA_WIDTH-1:0];
    assign bus.rsp_tag   = tag_q;
    assign bus.rsp_beat  = beat_q;
    assign bus.rsp_last  = last_q;
endmodule
